prog_mod_m_counter: RTL and testbench

Runtime-programmable mod-M counter for tick generation (baud, refresh, pixel timing) and event counting.
Adds up/down counting, count enable, synchronous load, modulus rewrite and one-shot mode, all in a single clock domain.
Drop-in successor for fixed mod-M tick generators: with default tie-offs it behaves as a free-running mod-M_DEFAULT up-counter.

---
 rtl/prog_mod_m_counter.sv | 84 ++++++++
 tb/tb_prog_mod_m_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prog_mod_m_counter.sv
// Runtime-programmable mod-M counter: up/down, enable, load, modulus rewrite, one-shot.
// Optional MOD_CNT_WRAPCNT_EN adds a saturating wrap_cnt output.
module prog_mod_m_counter #(
  parameter int N         = 8,
  parameter int M_DEFAULT = 10,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic         start,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         m_wr,
  input  logic [N-1:0] m_in,
`ifdef MOD_CNT_WRAPCNT_EN
  output logic [W-1:0] wrap_cnt,
`endif
  output logic [N-1:0] q,
  output logic         tick,
  output logic         done
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [N-1:0] m_reg;
  logic [N-1:0] t;
  logic [N-1:0] q_n;
  logic         step;
  logic         wrap;

  // m_reg == 0 selects the full 2^N range
  assign t = (m_reg == '0) ? {N{1'b1}} : m_reg - 1'b1;

  always_comb begin
    q_n     = q;
    state_n = state;
    step    = (state == RUN) & en & ~load;
    wrap    = up ? (q >= t) : (q == '0);
    tick    = step & wrap & ~reset;
    unique case (1'b1)
      load:       q_n = load_val;
      step &  up: q_n = wrap ? '0 : q + 1'b1;
      step & ~up: q_n = (wrap || q > t) ? t : q - 1'b1;
      default:    q_n = q;
    endcase
    unique case (state)
      RUN:     if (tick && oneshot) state_n = HALT;
      HALT:    if (start) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      m_reg <= N'(M_DEFAULT);
      state <= RUN;
    end else begin
      q     <= q_n;
      state <= state_n;
      if (m_wr) m_reg <= m_in;
    end
  end

  assign done = (state == HALT);

`ifdef MOD_CNT_WRAPCNT_EN
  always_ff @(posedge clk) begin
    if (reset || load || start)
      wrap_cnt <= '0;
    else if (tick && wrap_cnt != {W{1'b1}})
      wrap_cnt <= wrap_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_prog_mod_m_counter.sv
// Directed vector bench for prog_mod_m_counter (N=8 main instance, N=4 full-range instance).
// Build with MOD_CNT_WRAPCNT_EN to also exercise wrap_cnt.
module tb_prog_mod_m_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, oneshot, start, load, m_wr;
  logic [7:0] load_val, m_in, q;
  logic       tick, done;
  logic       r4, en4, mw4;
  logic [3:0] q4;
  logic       tick4, done4;
`ifdef MOD_CNT_WRAPCNT_EN
  logic [7:0] wrap_cnt;
  logic [7:0] wrap_cnt4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_mod_m_counter #(.N(8), .M_DEFAULT(10), .W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .oneshot(oneshot),
    .start(start), .load(load), .load_val(load_val), .m_wr(m_wr),
    .m_in(m_in),
`ifdef MOD_CNT_WRAPCNT_EN
    .wrap_cnt(wrap_cnt),
`endif
    .q(q), .tick(tick), .done(done)
  );

  prog_mod_m_counter #(.N(4), .M_DEFAULT(10), .W(8)) dut4 (
    .clk(clk), .reset(r4), .en(en4), .up(1'b1), .oneshot(1'b0),
    .start(1'b0), .load(1'b0), .load_val(4'd0), .m_wr(mw4),
    .m_in(4'd0),
`ifdef MOD_CNT_WRAPCNT_EN
    .wrap_cnt(wrap_cnt4),
`endif
    .q(q4), .tick(tick4), .done(done4)
  );

  typedef struct {
    bit       r, e, u, os, st, ld;
    bit [7:0] lv;
    bit       mw;
    bit [7:0] mi;
    bit [7:0] eq;
    bit       et, ed;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, e, u, os, st, ld, input bit [7:0] lv,
                     input bit mw, input bit [7:0] mi,
                     input bit [7:0] eq, input bit et, ed);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.os = os; v.st = st; v.ld = ld;
    v.lv = lv; v.mw = mw; v.mi = mi; v.eq = eq; v.et = et; v.ed = ed;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.r; en = v.e; up = v.u; oneshot = v.os; start = v.st;
    load = v.ld; load_val = v.lv; m_wr = v.mw; m_in = v.mi;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; oneshot = 1'b0; start = 1'b0;
    load = 1'b0; load_val = '0; m_wr = 1'b0; m_in = '0;
    r4 = 1'b1; en4 = 1'b0; mw4 = 1'b0;
    @(posedge clk);

    // reset state, with en asserted
    add(1,1,1,0,0,0,0,0,0, 0,0,0);
    // free-run up, mod 10
    for (int i = 0; i <= 10; i++)
      add(0,1,1,0,0,0,0,0,0, 8'(i % 10), i == 9, 0);
    // down count: 1 -> 0(tick),9..1,0(tick)
    add(0,1,0,0,0,0,0,0,0, 1,0,0);
    for (int i = 0; i <= 10; i++)
      add(0,1,0,0,0,0,0,0,0, (i == 0 || i == 10) ? 8'd0 : 8'(10 - i),
          i == 0 || i == 10, 0);
    // load suppresses tick; up to 7; modulus shrink to 4
    add(0,1,0,0,0,1,0,0,0, 9,0,0);
    for (int i = 0; i < 7; i++)
      add(0,1,1,0,0,0,0,0,0, 8'(i),0,0);
    add(0,0,1,0,0,0,0,1,4, 7,0,0);
    add(0,1,1,0,0,0,0,0,0, 7,1,0);
    for (int i = 0; i <= 4; i++)
      add(0,1,1,0,0,0,0,0,0, 8'(i % 4), i == 3, 0);
    // down from 7 with T=3 resyncs to 3 without tick
    add(0,1,1,0,0,1,7,0,0, 1,0,0);
    add(0,1,0,0,0,0,0,0,0, 7,0,0);
    add(0,1,0,0,0,0,0,0,0, 3,0,0);
    add(0,1,0,0,0,0,0,0,0, 2,0,0);
    add(0,1,0,0,0,0,0,0,0, 1,0,0);
    add(0,1,0,0,0,0,0,0,0, 0,1,0);
    // step alongside m_wr uses old T=3
    add(0,1,1,0,0,0,0,1,10, 3,1,0);
    // oneshot
    add(0,1,1,1,0,1,8,0,0, 0,0,0);
    add(0,1,1,1,0,0,0,0,0, 8,0,0);
    add(0,1,1,1,0,0,0,0,0, 9,1,0);
    for (int i = 0; i < 20; i++)
      add(0,1,1,1,0,0,0,0,0, 0,0,1);
    for (int i = 0; i < 3; i++)
      add(0,1,1,0,0,0,0,0,0, 0,0,1);
    add(0,1,1,0,1,0,0,0,0, 0,0,1);
    add(0,1,1,0,0,0,0,0,0, 0,0,0);
    add(0,1,1,0,0,0,0,0,0, 1,0,0);
    // load at q=9 wins over wrap
    add(0,1,1,0,0,1,7,0,0, 2,0,0);
    add(0,1,1,0,0,0,0,0,0, 7,0,0);
    add(0,1,1,0,0,0,0,0,0, 8,0,0);
    add(0,1,1,0,0,1,5,0,0, 9,0,0);
    add(0,1,1,0,0,0,0,0,0, 5,0,0);
    // HALT with q=6, m_reg=4, then reset
    add(0,0,1,0,0,0,0,1,4, 6,0,0);
    add(0,1,1,1,0,0,0,0,0, 6,1,0);
    add(0,1,1,1,0,1,6,0,0, 0,0,1);
    add(0,1,1,1,0,0,0,0,0, 6,0,1);
    add(1,1,1,1,0,0,0,0,0, 6,0,1);
    add(0,0,1,0,0,0,0,0,0, 0,0,0);
    add(0,1,1,0,0,1,9,0,0, 0,0,0);
    add(0,1,1,0,0,0,0,0,0, 9,1,0);
    // load with start in HALT enters RUN
    add(0,1,1,1,0,1,8,0,0, 0,0,0);
    add(0,1,1,1,0,0,0,0,0, 8,0,0);
    add(0,1,1,1,0,0,0,0,0, 9,1,0);
    add(0,1,1,1,1,1,3,0,0, 0,0,1);
    add(0,1,1,0,0,0,0,0,0, 3,0,0);
    add(0,1,1,0,0,0,0,0,0, 4,0,0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d.q", i), int'(q), int'(vq[i].eq));
      chk($sformatf("v%0d.tick", i), int'(tick), int'(vq[i].et));
      chk($sformatf("v%0d.done", i), int'(done), int'(vq[i].ed));
    end

`ifdef MOD_CNT_WRAPCNT_EN
    // wrap_cnt cleared by reset, counts ticks, saturates
    @(negedge clk);
    reset = 1'b1; en = 1'b1; up = 1'b1; oneshot = 1'b0;
    start = 1'b0; load = 1'b0; m_wr = 1'b0;
    @(negedge clk);
    #1 chk("wc_reset", int'(wrap_cnt), 0);
    reset = 1'b0; en = 1'b0; m_wr = 1'b1; m_in = 8'd1;
    @(negedge clk);
    m_wr = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1 chk("wc_count", int'(wrap_cnt), 10);
    for (int i = 0; i < 260; i++) @(negedge clk);
    #1 chk("wc_sat", int'(wrap_cnt), 255);
    chk("wc_sat_tick", int'(tick), 1);
    load = 1'b1; load_val = 8'd0;
    @(negedge clk);
    #1 chk("wc_load_clr", int'(wrap_cnt), 0);
    load = 1'b0; en = 1'b0;
`endif

    // N=4 instance, m_in=0 gives full 16-count period
    @(negedge clk);
    r4 = 1'b0; mw4 = 1'b1;
    #1 chk("n4_reset_q", int'(q4), 0);
    @(negedge clk);
    mw4 = 1'b0; en4 = 1'b1;
    for (int i = 0; i < 34; i++) begin
      #1;
      chk($sformatf("n4_q%0d", i), int'(q4), i % 16);
      chk($sformatf("n4_tick%0d", i), int'(tick4), int'(i % 16 == 15));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
